// File: rtl/cave_input_pkg.sv
// rtl/cave_input_pkg.sv - scan codes, player bit layout and joystick remap for cave_input
package cave_input_pkg;

  localparam int PLAYER_W = 10;
  localparam int JOY_W    = 11;
  localparam int KEY_W    = 11;

  // Player output bit positions
  localparam int BIT_UP      = 0;
  localparam int BIT_DOWN    = 1;
  localparam int BIT_LEFT    = 2;
  localparam int BIT_RIGHT   = 3;
  localparam int BIT_B1      = 4;
  localparam int BIT_B2      = 5;
  localparam int BIT_B3      = 6;
  localparam int BIT_START   = 7;
  localparam int BIT_COIN    = 8;
  localparam int BIT_SERVICE = 9;

  // Joystick input bit positions
  localparam int JOY_RIGHT   = 0;
  localparam int JOY_LEFT    = 1;
  localparam int JOY_DOWN    = 2;
  localparam int JOY_UP      = 3;
  localparam int JOY_B1      = 4;
  localparam int JOY_B2      = 5;
  localparam int JOY_B3      = 6;
  localparam int JOY_START   = 7;
  localparam int JOY_COIN    = 8;
  localparam int JOY_PAUSE   = 9;
  localparam int JOY_SERVICE = 10;

  localparam logic [7:0] SC_P1_UP      = 8'h75;
  localparam logic [7:0] SC_P1_DOWN    = 8'h72;
  localparam logic [7:0] SC_P1_LEFT    = 8'h6B;
  localparam logic [7:0] SC_P1_RIGHT   = 8'h74;
  localparam logic [7:0] SC_P1_B1      = 8'h14;
  localparam logic [7:0] SC_P1_B2      = 8'h11;
  localparam logic [7:0] SC_P1_B3      = 8'h29;
  localparam logic [7:0] SC_P1_START   = 8'h16;
  localparam logic [7:0] SC_P1_COIN    = 8'h2E;
  localparam logic [7:0] SC_P1_SERVICE = 8'h46;
  localparam logic [7:0] SC_PAUSE      = 8'h4D;
  localparam logic [7:0] SC_P2_UP      = 8'h2D;
  localparam logic [7:0] SC_P2_DOWN    = 8'h2B;
  localparam logic [7:0] SC_P2_LEFT    = 8'h23;
  localparam logic [7:0] SC_P2_RIGHT   = 8'h34;
  localparam logic [7:0] SC_P2_B1      = 8'h1C;
  localparam logic [7:0] SC_P2_B2      = 8'h1B;
  localparam logic [7:0] SC_P2_B3      = 8'h15;
  localparam logic [7:0] SC_P2_START   = 8'h1E;
  localparam logic [7:0] SC_P2_COIN    = 8'h36;
  localparam logic [7:0] SC_P2_SERVICE = 8'h45;

  typedef logic [PLAYER_W-1:0] player_t;

  // Pause has no slot in the player word; it is handled separately.
  function automatic player_t joy_to_player(input logic [JOY_W-1:0] joy);
    player_t p;
    p[BIT_UP]      = joy[JOY_UP];
    p[BIT_DOWN]    = joy[JOY_DOWN];
    p[BIT_LEFT]    = joy[JOY_LEFT];
    p[BIT_RIGHT]   = joy[JOY_RIGHT];
    p[BIT_B1]      = joy[JOY_B1];
    p[BIT_B2]      = joy[JOY_B2];
    p[BIT_B3]      = joy[JOY_B3];
    p[BIT_START]   = joy[JOY_START];
    p[BIT_COIN]    = joy[JOY_COIN];
    p[BIT_SERVICE] = joy[JOY_SERVICE];
    return p;
  endfunction

endpackage

// File: rtl/cave_input_if.sv
// rtl/cave_input_if.sv - keyboard/joystick inputs and player/pause outputs bundle
interface cave_input_if;
  import cave_input_pkg::*;

  logic [KEY_W-1:0]    ps2_key;
  logic [JOY_W-1:0]    joystick_0;
  logic [JOY_W-1:0]    joystick_1;
  logic [PLAYER_W-1:0] player1;
  logic [PLAYER_W-1:0] player2;
  logic                pause;

  modport master (
    output ps2_key, joystick_0, joystick_1,
    input  player1, player2, pause
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1,
    output player1, player2, pause
  );

endinterface

// File: rtl/cave_input_core.sv
// rtl/cave_input_core.sv - key latches, joystick merge, coin stretch and pause toggle
module cave_input_core #(
  parameter int COIN_HOLD = 1000000
) (
  input logic          clock,
  input logic          reset,
  cave_input_if.slave  bus
);
  import cave_input_pkg::*;

  logic       prev_toggle_q;
  logic       key_event;
  logic [7:0] key_code;
  logic       key_pressed;
  logic       key_bit8_unused;

  player_t p1_keys_q, p1_keys_d, p2_keys_q, p2_keys_d;
  logic    pause_key_q, pause_key_d;
  player_t p1_raw, p2_raw;
  logic    p1_coin, p2_coin;
  player_t player1_q, player1_d, player2_q, player2_d;
  logic    pause_raw, pause_prev_q, pause_q, pause_d;

  assign key_event       = bus.ps2_key[10] != prev_toggle_q;
  assign key_pressed     = bus.ps2_key[9];
  assign key_code        = bus.ps2_key[7:0];
  assign key_bit8_unused = bus.ps2_key[8];

  always_comb begin
    p1_keys_d   = p1_keys_q;
    p2_keys_d   = p2_keys_q;
    pause_key_d = pause_key_q;
    if (key_event) begin
      case (key_code)
        SC_P1_UP:      p1_keys_d[BIT_UP]      = key_pressed;
        SC_P1_DOWN:    p1_keys_d[BIT_DOWN]    = key_pressed;
        SC_P1_LEFT:    p1_keys_d[BIT_LEFT]    = key_pressed;
        SC_P1_RIGHT:   p1_keys_d[BIT_RIGHT]   = key_pressed;
        SC_P1_B1:      p1_keys_d[BIT_B1]      = key_pressed;
        SC_P1_B2:      p1_keys_d[BIT_B2]      = key_pressed;
        SC_P1_B3:      p1_keys_d[BIT_B3]      = key_pressed;
        SC_P1_START:   p1_keys_d[BIT_START]   = key_pressed;
        SC_P1_COIN:    p1_keys_d[BIT_COIN]    = key_pressed;
        SC_P1_SERVICE: p1_keys_d[BIT_SERVICE] = key_pressed;
        SC_PAUSE:      pause_key_d            = key_pressed;
        SC_P2_UP:      p2_keys_d[BIT_UP]      = key_pressed;
        SC_P2_DOWN:    p2_keys_d[BIT_DOWN]    = key_pressed;
        SC_P2_LEFT:    p2_keys_d[BIT_LEFT]    = key_pressed;
        SC_P2_RIGHT:   p2_keys_d[BIT_RIGHT]   = key_pressed;
        SC_P2_B1:      p2_keys_d[BIT_B1]      = key_pressed;
        SC_P2_B2:      p2_keys_d[BIT_B2]      = key_pressed;
        SC_P2_B3:      p2_keys_d[BIT_B3]      = key_pressed;
        SC_P2_START:   p2_keys_d[BIT_START]   = key_pressed;
        SC_P2_COIN:    p2_keys_d[BIT_COIN]    = key_pressed;
        SC_P2_SERVICE: p2_keys_d[BIT_SERVICE] = key_pressed;
        default: ;
      endcase
    end
  end

  assign p1_raw = p1_keys_q | joy_to_player(bus.joystick_0);
  assign p2_raw = p2_keys_q | joy_to_player(bus.joystick_1);

  cave_pulse_stretch #(.HOLD(COIN_HOLD)) u_coin1 (
    .clock (clock),
    .reset (reset),
    .in    (p1_raw[BIT_COIN]),
    .out   (p1_coin)
  );

  cave_pulse_stretch #(.HOLD(COIN_HOLD)) u_coin2 (
    .clock (clock),
    .reset (reset),
    .in    (p2_raw[BIT_COIN]),
    .out   (p2_coin)
  );

  always_comb begin
    player1_d           = p1_raw;
    player1_d[BIT_COIN] = p1_coin;
    player2_d           = p2_raw;
    player2_d[BIT_COIN] = p2_coin;
  end

  assign pause_raw = pause_key_q | bus.joystick_0[JOY_PAUSE] | bus.joystick_1[JOY_PAUSE];
  assign pause_d   = pause_q ^ (pause_raw & ~pause_prev_q);

  // prev_toggle follows the key toggle even in reset so no stale event fires on release.
  always_ff @(posedge clock) begin
    prev_toggle_q <= bus.ps2_key[10];
    if (reset) begin
      p1_keys_q    <= '0;
      p2_keys_q    <= '0;
      pause_key_q  <= 1'b0;
      player1_q    <= '0;
      player2_q    <= '0;
      pause_prev_q <= 1'b0;
      pause_q      <= 1'b0;
    end else begin
      p1_keys_q    <= p1_keys_d;
      p2_keys_q    <= p2_keys_d;
      pause_key_q  <= pause_key_d;
      player1_q    <= player1_d;
      player2_q    <= player2_d;
      pause_prev_q <= pause_raw;
      pause_q      <= pause_d;
    end
  end

  assign bus.player1 = player1_q;
  assign bus.player2 = player2_q;
  assign bus.pause   = pause_q;

endmodule

// File: rtl/cave_pulse_stretch.sv
// rtl/cave_pulse_stretch.sv - retriggerable minimum-length stretcher for a coin pulse
module cave_pulse_stretch #(
  parameter int HOLD = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam logic [23:0] RELOAD = 24'(HOLD - 1);

  logic [23:0] cnt_q, cnt_d;
  logic        prev_q;

  always_comb begin
    cnt_d = cnt_q;
    if (in && !prev_q) begin
      cnt_d = RELOAD;
    end else if (cnt_q != 24'd0) begin
      cnt_d = cnt_q - 24'd1;
    end
  end

  assign out = in | (cnt_q != 24'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= 24'd0;
      prev_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= in;
    end
  end

endmodule

// File: rtl/cave_input.sv
// rtl/cave_input.sv - arcade input mapper: PS/2 keys and two joysticks to player words
module cave_input import cave_input_pkg::*; #(
  parameter int COIN_HOLD = 1000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [KEY_W-1:0]    ps2_key,
  input  logic [JOY_W-1:0]    joystick_0,
  input  logic [JOY_W-1:0]    joystick_1,
  output logic [PLAYER_W-1:0] player1,
  output logic [PLAYER_W-1:0] player2,
  output logic                pause
);

  cave_input_if bus ();

  assign bus.ps2_key    = ps2_key;
  assign bus.joystick_0 = joystick_0;
  assign bus.joystick_1 = joystick_1;
  assign player1        = bus.player1;
  assign player2        = bus.player2;
  assign pause          = bus.pause;

  cave_input_core #(.COIN_HOLD(COIN_HOLD)) u_core (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

endmodule

// File: tb/tb_cave_input.sv
// tb/tb_cave_input.sv - randomized and directed checks of cave_input against a behavioural model
module tb_cave_input;
  import cave_input_pkg::*;

  localparam int HOLD = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cave_input_if bus ();

  cave_input #(.COIN_HOLD(HOLD)) dut (
    .clock      (clock),
    .reset      (reset),
    .ps2_key    (bus.ps2_key),
    .joystick_0 (bus.joystick_0),
    .joystick_1 (bus.joystick_1),
    .player1    (bus.player1),
    .player2    (bus.player2),
    .pause      (bus.pause)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] p1_codes [10] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h16, 8'h2E, 8'h46};
  logic [7:0] p2_codes [10] = '{8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h15, 8'h1E, 8'h36, 8'h45};
  int         joy_idx  [10] = '{3, 2, 1, 0, 4, 5, 6, 7, 8, 10};
  logic [7:0] pool     [23] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h16, 8'h2E, 8'h46,
                                8'h4D, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h15, 8'h1E, 8'h36,
                                8'h45, 8'h00, 8'h55};

  bit         keys [256];
  bit         prev_tog, prev_c1, prev_c2, prev_p;
  int         last_rise1, last_rise2, cyc;
  logic       exp_pause;
  logic [9:0] exp_p1, exp_p2;
  int         hi;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Outputs after the next edge: keyboard state seen one cycle later than joysticks,
  // coin high while raw or within HOLD cycles of the latest rise.
  task automatic model_step();
    logic [9:0] p1, p2;
    bit r1, r2, rp;
    cyc++;
    if (reset) begin
      foreach (keys[i]) keys[i] = 1'b0;
      prev_c1 = 0; prev_c2 = 0; prev_p = 0;
      last_rise1 = -1000; last_rise2 = -1000;
      exp_pause = 1'b0; exp_p1 = '0; exp_p2 = '0;
      prev_tog = bus.ps2_key[10];
      return;
    end
    for (int b = 0; b < 10; b++) begin
      p1[b] = keys[p1_codes[b]] | bus.joystick_0[joy_idx[b]];
      p2[b] = keys[p2_codes[b]] | bus.joystick_1[joy_idx[b]];
    end
    r1 = p1[8];
    if (r1 && !prev_c1) last_rise1 = cyc;
    prev_c1 = r1;
    p1[8] = r1 || (cyc - last_rise1 < HOLD);
    r2 = p2[8];
    if (r2 && !prev_c2) last_rise2 = cyc;
    prev_c2 = r2;
    p2[8] = r2 || (cyc - last_rise2 < HOLD);
    rp = keys[8'h4D] | bus.joystick_0[9] | bus.joystick_1[9];
    if (rp && !prev_p) exp_pause = ~exp_pause;
    prev_p = rp;
    exp_p1 = p1;
    exp_p2 = p2;
    if (bus.ps2_key[10] != prev_tog) keys[bus.ps2_key[7:0]] = bus.ps2_key[9];
    prev_tog = bus.ps2_key[10];
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    @(negedge clock);
    check("player1", bus.player1, exp_p1);
    check("player2", bus.player2, exp_p2);
    check("pause", bus.pause, exp_pause);
  endtask

  task automatic kbd(input logic [7:0] code, input logic pressed);
    bus.ps2_key = {~bus.ps2_key[10], pressed, 1'b0, code};
    step();
  endtask

  initial begin
    cyc = 0;
    reset = 1'b1;
    bus.ps2_key = 11'h400;
    bus.joystick_0 = '0;
    bus.joystick_1 = '0;
    @(negedge clock);
    repeat (3) step();
    check("rst_p1", bus.player1, 0);
    check("rst_pause", bus.pause, 0);

    reset = 1'b0;
    repeat (3) step();
    check("rel_p1", bus.player1, 0);
    check("rel_p2", bus.player2, 0);

    kbd(8'h75, 1'b1);
    check("up_lat1", bus.player1[0], 0);
    step();
    check("up_lat2", bus.player1[0], 1);
    kbd(8'h75, 1'b0);
    check("upr_lat1", bus.player1[0], 1);
    step();
    check("upr_lat2", bus.player1[0], 0);

    kbd(8'h00, 1'b1);
    step(); step();
    check("code00_p1", bus.player1, 0);
    check("code00_p2", bus.player2, 0);
    check("code00_pause", bus.pause, 0);

    bus.joystick_1[8] = 1'b1;
    step();
    bus.joystick_1[8] = 1'b0;
    hi = bus.player2[8];
    for (int i = 0; i < 20; i++) begin step(); hi += bus.player2[8]; end
    check("coin_single", hi, 8);

    bus.joystick_1[8] = 1'b1;
    step();
    bus.joystick_1[8] = 1'b0;
    hi = bus.player2[8];
    for (int i = 0; i < 4; i++) begin step(); hi += bus.player2[8]; end
    bus.joystick_1[8] = 1'b1;
    step();
    hi += bus.player2[8];
    bus.joystick_1[8] = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); hi += bus.player2[8]; end
    check("coin_retrig", hi, 13);

    bus.joystick_1[8] = 1'b1;
    step();
    bus.joystick_1[8] = 1'b0;
    repeat (4) step();
    check("coin_mid", bus.player2[8], 1);
    reset = 1'b1;
    step();
    check("coin_rst", bus.player2[8], 0);
    reset = 1'b0;
    repeat (10) step();
    check("coin_after_rst", bus.player2[8], 0);

    bus.joystick_0[9] = 1'b1;
    repeat (20) step();
    check("pause_on", bus.pause, 1);
    bus.joystick_0[9] = 1'b0;
    repeat (3) step();
    check("pause_hold", bus.pause, 1);
    kbd(8'h4D, 1'b1);
    step();
    check("pause_off", bus.pause, 0);
    kbd(8'h4D, 1'b0);
    step(); step();
    check("pause_stay", bus.pause, 0);

    bus.joystick_1[3] = 1'b1;
    kbd(8'h2D, 1'b1);
    check("p2up_both", bus.player2[0], 1);
    kbd(8'h2D, 1'b0);
    step(); step();
    check("p2up_joy", bus.player2[0], 1);
    bus.joystick_1[3] = 1'b0;
    step();
    check("p2up_rel", bus.player2[0], 0);

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.ps2_key = {~bus.ps2_key[10], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       pool[$urandom_range(0, 22)]};
      end
      if ($urandom_range(0, 7) == 0) begin
        int j;
        j = $urandom_range(0, 10);
        if ($urandom_range(0, 1) == 1) bus.joystick_0[j] = ~bus.joystick_0[j];
        else bus.joystick_1[j] = ~bus.joystick_1[j];
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
